// File: rtl/tristate_serial_tx_pkg.sv
// tristate_serial_tx_pkg: shared state encoding, line-level constants and
// frame-length helper. TRISTATE_SERIAL_TX_PARITY_EN adds the parity bit.
package tristate_serial_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEAD   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5,
        S_GUARD  = 3'd6
    } state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;
    localparam logic TX_HIGHZ      = 1'b1;

`ifdef TRISTATE_SERIAL_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Driven cycles of one stand-alone frame (LEAD included).
    function automatic int frame_len(
        input int width,
        input int lead,
        input int guard
    );
        return lead + width + 2 + PARITY_BITS + guard;
    endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// tx_shift_reg: WIDTH-bit parallel-load, MSB-first shift register.
// Ports: clk, rst_n (sync, active-low), i_load, i_shift, i_data[WIDTH-1:0],
// o_sout (current MSB), o_parity (running XOR, TRISTATE_SERIAL_TX_PARITY_EN).
module tx_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
`ifdef TRISTATE_SERIAL_TX_PARITY_EN
    output logic             o_parity,
`endif
    output logic             o_sout
);

    logic [WIDTH-1:0] r_sreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sreg <= '0;
        end else if (i_load) begin
            r_sreg <= i_data;
        end else if (i_shift) begin
            r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
        end
    end

    assign o_sout = r_sreg[WIDTH-1];

`ifdef TRISTATE_SERIAL_TX_PARITY_EN
    // Accumulates every bit as it leaves the MSB; after WIDTH
    // shifts it holds the even parity of the whole word.
    logic r_par;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (i_load) begin
            r_par <= 1'b0;
        end else if (i_shift) begin
            r_par <= r_par ^ r_sreg[WIDTH-1];
        end
    end

    assign o_parity = r_par;
`endif

endmodule

// File: rtl/tristate_serial_tx.sv
// tristate_serial_tx: frames words (lead, start, MSB-first data, stop,
// guard) onto a tri-state pair; releases to high-Z when idle.
// Ports: clk, rst_n (sync, active-low), in_data/in_valid/in_ready
// handshake, tx_o (buffer data), tx_t (1 = high-Z), busy.
// Optional parity bit: define TRISTATE_SERIAL_TX_PARITY_EN.
module tristate_serial_tx
    import tristate_serial_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEAD  = 2,
    parameter int GUARD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx_o,
    output logic             tx_t,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [3:0] LEAD_LAST =
        4'((LEAD == 0) ? 0 : LEAD - 1);
    localparam logic [3:0] GUARD_LAST = 4'(GUARD - 1);

    state_t        r_state;
    logic [BW-1:0] r_bcnt;
    logic [3:0]    r_gcnt;
    logic          r_tx_o;
    logic          r_tx_t;
    logic          r_busy;

    logic w_last_guard;
    logic w_accept;
    logic w_shift;
    logic w_sout;
`ifdef TRISTATE_SERIAL_TX_PARITY_EN
    logic w_par;
`endif

    assign w_last_guard = (r_state == S_GUARD) &&
                          (r_gcnt == GUARD_LAST);
    assign in_ready = (r_state == S_IDLE) || w_last_guard;
    assign w_accept = in_valid && in_ready;

    // The register presents the next bit one edge ahead of the
    // registered tx_o, so shifting starts on the START edge.
    assign w_shift = (r_state == S_START) ||
                     ((r_state == S_DATA) && (r_bcnt != BIT_LAST));

    tx_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_accept),
        .i_shift  (w_shift),
        .i_data   (in_data),
`ifdef TRISTATE_SERIAL_TX_PARITY_EN
        .o_parity (w_par),
`endif
        .o_sout   (w_sout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_bcnt  <= '0;
            r_gcnt  <= '0;
            r_tx_o  <= TX_IDLE_LEVEL;
            r_tx_t  <= TX_HIGHZ;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_tx_t <= 1'b0;
                        r_busy <= 1'b1;
                        r_gcnt <= '0;
                        if (LEAD == 0) begin
                            r_state <= S_START;
                            r_tx_o  <= 1'b0;
                        end else begin
                            r_state <= S_LEAD;
                            r_tx_o  <= TX_IDLE_LEVEL;
                        end
                    end
                end
                S_LEAD: begin
                    if (r_gcnt == LEAD_LAST) begin
                        r_state <= S_START;
                        r_tx_o  <= 1'b0;
                    end else begin
                        r_gcnt <= r_gcnt + 4'd1;
                    end
                end
                S_START: begin
                    r_state <= S_DATA;
                    r_bcnt  <= '0;
                    r_tx_o  <= w_sout;
                end
                S_DATA: begin
                    if (r_bcnt == BIT_LAST) begin
`ifdef TRISTATE_SERIAL_TX_PARITY_EN
                        r_state <= S_PARITY;
                        r_tx_o  <= w_par;
`else
                        r_state <= S_STOP;
                        r_tx_o  <= TX_IDLE_LEVEL;
`endif
                    end else begin
                        r_bcnt <= r_bcnt + 1'b1;
                        r_tx_o <= w_sout;
                    end
                end
                S_PARITY: begin
                    r_state <= S_STOP;
                    r_tx_o  <= TX_IDLE_LEVEL;
                end
                S_STOP: begin
                    r_state <= S_GUARD;
                    r_gcnt  <= '0;
                    r_tx_o  <= TX_IDLE_LEVEL;
                end
                S_GUARD: begin
                    if (r_gcnt == GUARD_LAST) begin
                        if (in_valid) begin
                            // Back-to-back: keep driving, skip LEAD.
                            r_state <= S_START;
                            r_tx_o  <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx_o  <= TX_IDLE_LEVEL;
                            r_tx_t  <= TX_HIGHZ;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_gcnt <= r_gcnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx_o  <= TX_IDLE_LEVEL;
                    r_tx_t  <= TX_HIGHZ;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_o = r_tx_o;
    assign tx_t = r_tx_t;
    assign busy = r_busy;

endmodule

// File: tb/tb_tristate_serial_tx.sv
// tb_tristate_serial_tx: table, hand-written and random frames for two
// configurations (LEAD=2/GUARD=1 and LEAD=0/GUARD=3).
module tb_tristate_serial_tx;
    import tristate_serial_tx_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, tx_o, tx_t, busy;
    logic [7:0] b_data = 8'h00;
    logic       b_valid = 1'b0;
    logic       b_ready, b_tx_o, b_tx_t, b_busy;

    int n_checks = 0;
    int n_fail = 0;

    logic exp_q[$];
    logic got_q[$];
    logic rdy_q[$];

    typedef struct {
        logic [7:0]  data;
        logic [12:0] bits;
        logic        par;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;

    tristate_serial_tx #(
        .WIDTH (8),
        .LEAD  (2),
        .GUARD (1)
    ) u_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx_o     (tx_o),
        .tx_t     (tx_t),
        .busy     (busy)
    );

    tristate_serial_tx #(
        .WIDTH (8),
        .LEAD  (0),
        .GUARD (3)
    ) u_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (b_data),
        .in_valid (b_valid),
        .in_ready (b_ready),
        .tx_o     (b_tx_o),
        .tx_t     (b_tx_t),
        .busy     (b_busy)
    );

    task automatic check(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line levels of one frame, straight from the framing rules.
    function automatic void model(
        input logic [7:0] w,
        input int         lead,
        input int         guard
    );
        exp_q.delete();
        for (int i = 0; i < lead; i++) exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        for (int k = 7; k >= 0; k--) exp_q.push_back(w[k]);
`ifdef TRISTATE_SERIAL_TX_PARITY_EN
        exp_q.push_back(^w);
`endif
        exp_q.push_back(1'b1);
        for (int i = 0; i < guard; i++) exp_q.push_back(1'b1);
    endfunction

    function automatic logic cur_t(input bit sel);
        return sel ? b_tx_t : tx_t;
    endfunction

    task automatic run_frame(input bit sel, input logic [7:0] w);
        int n;
        int lead;
        int guard;
        lead  = sel ? 0 : 2;
        guard = sel ? 3 : 1;
        model(w, lead, guard);
        if (sel) begin
            b_data = w;
            b_valid = 1'b1;
        end else begin
            in_data = w;
            in_valid = 1'b1;
        end
        check("ready_idle", sel ? b_ready : in_ready, 1);
        tick();
        b_valid = 1'b0;
        in_valid = 1'b0;
        got_q.delete();
        rdy_q.delete();
        n = 0;
        while (cur_t(sel) == 1'b0 && n < 64) begin
            got_q.push_back(sel ? b_tx_o : tx_o);
            rdy_q.push_back(sel ? b_ready : in_ready);
            check("busy_frame", sel ? b_busy : busy, 1);
            tick();
            n++;
        end
        check("frame_len", got_q.size(),
              frame_len(8, lead, guard));
        check("model_len", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check("frame_bit", got_q[i], exp_q[i]);
            check("frame_rdy", rdy_q[i], i == exp_q.size() - 1);
        end
        check("after_t", cur_t(sel), 1);
        check("after_o", sel ? b_tx_o : tx_o, 1);
        check("after_busy", sel ? b_busy : busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [12:0] packed_bits;
        logic        cat_q[$];
        int          n;
        int          l1;
        int          drv;

        tbl[0] = '{8'hA5, 13'b1101010010111, 1'b0};
        tbl[1] = '{8'h07, 13'b1100000011111, 1'b1};
        tbl[2] = '{8'h3C, 13'b1100011110011, 1'b0};
        tbl[3] = '{8'hFF, 13'b1101111111111, 1'b0};
        tbl[4] = '{8'h00, 13'b1100000000011, 1'b0};
        tbl[5] = '{8'h81, 13'b1101000000111, 1'b0};

        tick();
        tick();
        check("rst_t", tx_t, 1);
        check("rst_o", tx_o, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_t", tx_t, 1);
            check("idle_o", tx_o, 1);
            check("idle_ready", in_ready, 1);
            check("idle_busy", busy, 0);
        end

        for (int i = 0; i < 6; i++) begin
            run_frame(1'b0, tbl[i].data);
`ifdef TRISTATE_SERIAL_TX_PARITY_EN
            check("vec_par", got_q[11], tbl[i].par);
`else
            packed_bits = '0;
            for (int j = 0; j < 13; j++)
                packed_bits = {packed_bits[11:0], got_q[j]};
            check("vec_bits", packed_bits, tbl[i].bits);
`endif
        end

        // Back-to-back: 0x3C then 0xFF with in_valid held.
        model(8'h3C, 2, 1);
        cat_q = exp_q;
        l1 = exp_q.size();
        model(8'hFF, 0, 1);
        for (int i = 0; i < exp_q.size(); i++)
            cat_q.push_back(exp_q[i]);
        in_data = 8'h3C;
        in_valid = 1'b1;
        tick();
        in_data = 8'hFF;
        got_q.delete();
        n = 0;
        while (tx_t == 1'b0 && n < 64) begin
            got_q.push_back(tx_o);
            check("b2b_ready", in_ready,
                  (n == l1 - 1) || (n == cat_q.size() - 1));
            tick();
            if (n == l1 - 1) in_valid = 1'b0;
            n++;
        end
        check("b2b_len", got_q.size(), cat_q.size());
        for (int i = 0; i < cat_q.size() && i < got_q.size(); i++)
            check("b2b_bit", got_q[i], cat_q[i]);
        check("b2b_start2", got_q[l1], 0);

        // Reset during DATA bit 3 of 0x81.
        in_data = 8'h81;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("mid_pre_t", tx_t, 0);
        check("mid_pre_o", tx_o, 0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_t", tx_t, 1);
        check("mid_rst_o", tx_o, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 1);
        rst_n = 1'b1;
        drv = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (tx_t == 1'b0) drv++;
        end
        check("mid_no_drive", drv, 0);

        // LEAD=0, GUARD=3 instance.
        run_frame(1'b1, 8'h00);
        check("b_first_start", got_q[0], 0);
        for (int i = 0; i < 6; i++)
            run_frame(1'b1, 8'($urandom));

        // Random words with random idle gaps.
        for (int i = 0; i < 20; i++) begin
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) tick();
            run_frame(1'b0, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
